// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLL    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

endpackage

// File: rtl/alu_mdu.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on unsigned magnitudes,
// one bit per cycle, with the first bit folded into the start cycle.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [4:0]         op_q, op_d;

  logic               a_sgn, b_sgn, sa, sb, is_div_in;
  logic [WIDTH-1:0]   ma, mb, quo, rem;
  logic [2*WIDTH-1:0] prod;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] opnd,
                                               input logic is_div);
    logic [WIDTH:0] t;
    if (is_div) begin
      t = acc[2*WIDTH-1:WIDTH-1];
      if (t >= {1'b0, opnd}) begin
        t = t - {1'b0, opnd};
        step = {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        step = {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      t = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      step = {t, acc[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    is_div_in = op[2];
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa = a_sgn & a[WIDTH-1];
    sb = b_sgn & b[WIDTH-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;

    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    op_d   = op_q;
    if (start) begin
      op_d   = op;
      neg_d  = (op == OP_REM) ? sa : (sa ^ sb);
      opnd_d = is_div_in ? mb : ma;
      acc_d  = step(is_div_in ? {{WIDTH{1'b0}}, ma} : {{WIDTH{1'b0}}, mb}, opnd_d, is_div_in);
      cnt_d  = CW'(WIDTH - 1);
    end else if (run && cnt_q != '0) begin
      acc_d = step(acc_q, opnd_q, op_q[2]);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      op_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      op_q   <= op_d;
    end
  end

  assign last = (cnt_q == CW'(1));

  // Sign correction and word selection, registered by the top in its FIX state
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                         result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:                result = neg_q ? -quo : quo;
      OP_REM, OP_REMU:                result = neg_q ? -rem : rem;
      default:                        result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake: base ops finish in one cycle, mul/div ops run
// through the iterative MDU and a FIX cycle before the result is presented.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept, is_m, mdu_start, mdu_run, mdu_last;
  logic [WIDTH-1:0] mdu_result, base_res, b_eff, fast_res;
  logic [WIDTH:0]   sum;
  logic             sub, arith, ovf, base_c, base_v, fast_hit;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;
  assign is_m      = MDU_EN && (op[4:3] == 2'b10);
  assign mdu_run   = (state_q == MUL) || (state_q == DIV);

  // One shared adder serves ADD, SUB and both compares
  always_comb begin
    sub    = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    arith  = sub || (op == OP_ADD);
    b_eff  = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
    ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    base_c = arith & sum[WIDTH];
    base_v = arith & ovf;
    case (op)
      OP_ADD, OP_SUB: base_res = sum[WIDTH-1:0];
      OP_AND:         base_res = a & b;
      OP_OR:          base_res = a | b;
      OP_XOR:         base_res = a ^ b;
      OP_SLT:         base_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_SLL:         base_res = a << b[SHW-1:0];
      OP_SRL:         base_res = a >> b[SHW-1:0];
      OP_SRA:         base_res = $signed(a) >>> b[SHW-1:0];
      OP_SLTU:        base_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      default:        base_res = '0;
    endcase
  end

  // Divide by zero and signed overflow bypass the iterative unit
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if ((op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU)) begin
      if (b == '0) begin
        fast_hit = 1'b1;
        fast_res = op[1] ? a : '1;
      end else if (((op == OP_DIV) || (op == OP_REM)) &&
                   (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
        fast_hit = 1'b1;
        fast_res = op[1] ? '0 : a;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mdu_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept) begin
          if (is_m && !fast_hit) begin
            state_d   = op[2] ? DIV : MUL;
            mdu_start = 1'b1;
          end else begin
            state_d  = DONE;
            result_d = is_m ? fast_res : base_res;
            flags_d  = is_m ? mk_flags(fast_res, 1'b0, 1'b0) : mk_flags(base_res, base_c, base_v);
          end
        end
      end
      MUL, DIV: begin
        if (mdu_last) state_d = FIX;
      end
      FIX: begin
        state_d  = DONE;
        result_d = mdu_result;
        flags_d  = mk_flags(mdu_result, 1'b0, 1'b0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  if (MDU_EN) begin : g_mdu
    alu_mdu #(.WIDTH(WIDTH)) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdu_start),
      .run    (mdu_run),
      .op     (op),
      .a      (a),
      .b      (b),
      .last   (mdu_last),
      .result (mdu_result)
    );
  end else begin : g_no_mdu
    assign mdu_last   = 1'b0;
    assign mdu_result = '0;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized ops against an
// arithmetic reference model; a separate monitor checks every consumed result.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  a, b, result;
  logic [4:0]    op;
  logic [3:0]    flags;

  logic          in_valid0, in_ready0, out_valid0, busy0;
  logic          out_ready0 = 1'b1;
  logic [4:0]    op0;
  logic [W-1:0]  result0;
  logic [3:0]    flags0;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  bit   rand_ready_en = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  alu_seq #(.WIDTH(W), .MDU_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .op(op0), .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .flags(flags0), .busy(busy0)
  );

  // Reference built from the arithmetic meaning of each op, using 64-bit integers
  function automatic exp_t ref_model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, ux, uy, t;
    logic [63:0] p;
    logic c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    c = 1'b0;
    v = 1'b0;
    t = sx - sy;
    e.res = '0;
    case (o)
      5'd0: begin
        t = sx + sy;
        e.res = x + y;
        c = ((ux + uy) >= 64'sd4294967296);
        v = (t > SMAX) || (t < SMIN);
      end
      5'd1, 5'd5, 5'd9: begin
        c = (x >= y);
        v = (t > SMAX) || (t < SMIN);
        if (o == 5'd1) e.res = x - y;
        else if (o == 5'd5) e.res = {31'b0, sx < sy};
        else e.res = {31'b0, x < y};
      end
      5'd2: e.res = x & y;
      5'd3: e.res = x | y;
      5'd4: e.res = x ^ y;
      5'd6: e.res = x << y[4:0];
      5'd7: e.res = x >> y[4:0];
      5'd8: e.res = W'($signed(x) >>> y[4:0]);
      5'd16: begin p = 64'(sx * sy); e.res = p[31:0]; end
      5'd17: begin p = 64'(sx * sy); e.res = p[63:32]; end
      5'd18: begin p = 64'(sx * uy); e.res = p[63:32]; end
      5'd19: begin p = {32'b0, x} * {32'b0, y}; e.res = p[63:32]; end
      5'd20: e.res = (y == 0) ? '1 : W'(sx / sy);
      5'd21: e.res = (y == 0) ? '1 : x / y;
      5'd22: e.res = (y == 0) ? x : W'(sx % sy);
      5'd23: e.res = (y == 0) ? x : x % y;
      default: e.res = '0;
    endcase
    e.op  = o;
    e.flg = {v, c, e.res[W-1], e.res == 0};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: actual=timeout required=handshake", name);
  endtask

  task automatic applyStimulus(input logic [4:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input bit set_ready, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    @(posedge clk);
    #1;
    op = o;
    a = va;
    b = vb;
    in_valid = 1'b1;
    if (set_ready) out_ready = 1'b1;
    while (!done && waits < 200) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin
        @(posedge clk);
        sb.push_back(ref_model(o, va, vb));
        done = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
    if (!done) report_timeout($sformatf("accept op%0d", o));
  endtask

  task automatic waitOutput(input string name, input int exp_lat, input logic [W-1:0] exp_res);
    int n, busy_bad;
    n = 0;
    busy_bad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (in_ready) busy_bad++;
    end
    if (!out_valid) report_timeout({name, "_valid"});
    else begin
      checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
      checkOutput({name, "_result"}, result, exp_res);
      if (exp_lat > 1) checkOutput({name, "_in_ready_low"}, 32'(busy_bad), 32'd0);
    end
  endtask

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every result actually handed over must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_output: actual=%h required=none", result);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("sb_result op%0d", e.op), result, e.res);
        checkOutput($sformatf("sb_flags op%0d", e.op), {28'b0, flags}, {28'b0, e.flg});
      end
    end
  end

  initial begin
    int w, sel, mode, tries;
    logic [4:0] ro;
    logic [W-1:0] ra, rb;

    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid0 = 1'b0; op0 = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0, w);
    waitOutput("add_ovf", 1, 32'h80000000);
    checkOutput("add_ovf_flags", 32'(flags), 32'b1010);
    applyStimulus(OP_SUB, 32'd5, 32'd7, 1'b0, w);
    waitOutput("sub", 1, 32'hFFFFFFFE);
    checkOutput("sub_flags", 32'(flags), 32'b0010);
    applyStimulus(OP_SLTU, 32'd5, 32'd7, 1'b0, w);
    waitOutput("sltu", 1, 32'd1);
    applyStimulus(OP_SLT, 32'h80000000, 32'd1, 1'b0, w);
    waitOutput("slt", 1, 32'd1);

    applyStimulus(OP_MUL, 32'hFFFFFFFD, 32'd7, 1'b0, w);
    waitOutput("mul", 33, 32'hFFFFFFEB);
    applyStimulus(OP_MULH, 32'hFFFFFFFD, 32'd7, 1'b0, w);
    waitOutput("mulh", 33, 32'hFFFFFFFF);
    applyStimulus(OP_MULHU, 32'hFFFFFFFD, 32'd7, 1'b0, w);
    waitOutput("mulhu", 33, 32'h00000006);

    applyStimulus(OP_DIV, 32'd100, 32'd0, 1'b0, w);
    waitOutput("div_by_zero", 1, 32'hFFFFFFFF);
    applyStimulus(OP_REM, 32'd100, 32'd0, 1'b0, w);
    waitOutput("rem_by_zero", 1, 32'd100);
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, w);
    waitOutput("div_ovf", 1, 32'h80000000);
    applyStimulus(OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0, w);
    waitOutput("rem_ovf", 1, 32'd0);

    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0, w);
    waitOutput("divu", 33, 32'd14);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_result", result, 32'd14);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus(OP_REMU, 32'd100, 32'd7, 1'b1, w);
    checkOutput("reaccept_same_cycle", 32'(w), 32'd1);
    waitOutput("remu", 33, 32'd2);

    applyStimulus(OP_MUL, 32'd12345, 32'd678, 1'b0, w);
    repeat (10) @(negedge clk);
    checkOutput("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_result", result, 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0, w);
    waitOutput("post_reset_add", 1, 32'd2);

    @(posedge clk);
    #1;
    op0 = OP_MUL;
    a = 32'd5;
    b = 32'd3;
    in_valid0 = 1'b1;
    @(negedge clk);
    checkOutput("nomdu_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(negedge clk);
    checkOutput("nomdu_out_valid", 32'(out_valid0), 32'd1);
    checkOutput("nomdu_result", result0, 32'd0);
    checkOutput("nomdu_flags", 32'(flags0), 32'b0001);
    checkOutput("nomdu_busy", 32'(busy0), 32'd1);

    rand_ready_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) ro = 5'($urandom_range(0, 9));
      else if (sel < 8) ro = 5'(16 + $urandom_range(0, 7));
      else ro = 5'($urandom_range(0, 31));
      mode = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      if (mode == 0) rb = '0;
      else if (mode == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (mode == 2) begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 20)); end
      else if (mode == 3) rb = 32'($urandom_range(0, 40));
      applyStimulus(ro, ra, rb, 1'b0, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    tries = 0;
    while (sb.size() != 0 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    checkOutput("drain_outstanding", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parameterised, registered ALU with an RV32M-style iterative multiply/divide unit behind a valid/ready handshake.
- Replaces the single-cycle datapath ALU in the execute stage wherever multi-cycle ops are needed.
- Base ops complete in 1 cycle; M ops take WIDTH+1 cycles.
- Result and flags stay held until consumed.

Parameters:
- WIDTH, 32: operand/result width; >= 8.
- MDU_EN, 1: 1 = mul/div ops supported; 0 = M ops are treated as illegal and the MDU is not instantiated.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted
- a  in  WIDTH  operand A (rs1)
- b  in  WIDTH  operand B (rs2/imm)
- op  in  5  operation code (see Behaviour)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- flags  out  4  [0]=Z [1]=N [2]=C [3]=V, registered
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; result=0; flags=0; busy=0; MDU counter=0. in_ready=1 after release. Reset mid-op abandons the op; no output.
- Accept: in_valid && in_ready at edge T; a, b and op are captured.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Op codes, base (op[4]=0):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 SLTU.
  - 10..15 are illegal.
- Op codes, M (op[4]=1):
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - 24..31 are illegal.
- Arithmetic rules:
  - SUB = a + ~b + 1.
  - C = carry-out of the WIDTH-bit adder, for ADD/SUB/SLT/SLTU only; else 0.
  - V = signed overflow, for ADD/SUB/SLT/SLTU only; else 0.
  - SLT = N xor V of (a-b).
  - SLTU = ~C of (a-b).
  - Shift amount = b[$clog2(WIDTH)-1:0].
  - Z and N are computed from the final result for every op.
- Base ops and illegal ops: state IDLE -> DONE; out_valid=1 at T+1. Illegal op gives result=0, Z=1, all other flags 0.
- MUL family: IDLE -> MUL.
  - Operands are converted to magnitudes per signedness.
  - Shift-add runs one bit per cycle for WIDTH cycles using a 2*WIDTH accumulator.
  - Then FIX: sign correction; select low word (MUL) or high word (others).
  - Then DONE: out_valid at T+WIDTH+1.
- DIV family: IDLE -> DIV.
  - Restoring division runs one bit per cycle for WIDTH cycles.
  - Then FIX: quotient sign = sa^sb; remainder takes the dividend's sign.
  - Then DONE: out_valid at T+WIDTH+1.
- Fast paths (DONE at T+1):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed a==MIN and b==-1: DIV gives MIN; REM gives 0.
- Iteration counter is $clog2(WIDTH)+1 bits: loads WIDTH-1 and transitions to FIX at 0.
- DONE state:
  - result and flags are held stable while out_ready=0.
  - On out_ready=1 the state goes to IDLE, or re-accepts in the same cycle if in_valid=1.
  - out_valid drops only when out_ready=1 and no new base op is accepted.
  - A new base op accepted in DONE gives out_valid=1 again the next cycle with the new result.
- in_valid while busy in MUL/DIV/FIX is ignored; the source must hold its operation.

Decomposition:
- Package alu_pkg contains:
  - op code localparams;
  - flag index constants (FLAG_Z/N/C/V);
  - state enum {IDLE, MUL, DIV, FIX, DONE}.
- One sub-module, alu_mdu: iterative mul/div datapath with start/done, counter and accumulator. Instantiated only under MDU_EN.
- Base ops stay combinational in alu_seq.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> out_valid at T+1; result 0x80000000; flags Z=0 N=1 C=0 V=1.
- SUB a=5, b=7 -> result 0xFFFFFFFE; N=1, C=0, V=0; then SLTU 5,7 -> result 1; SLT 0x80000000,1 -> result 1.
- MUL a=0xFFFFFFFD, b=7 -> result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
  - out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIV a=100, b=0 -> 0xFFFFFFFF at T+1; REM -> 100.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIVU 100/7 with out_ready=0 for 5 cycles after out_valid -> result 14 held stable, in_ready=0.
  - Release out_ready with in_valid=1 and REMU 100/7 queued -> accepted the same cycle; result 2 after 33 cycles.
- rst_n pulsed low 10 cycles into a MUL -> out_valid=0, result=0 immediately; in_ready=1 after release.
  - Next ADD 1+1 -> result 2 at T+1; no stale MUL result appears.
- MDU_EN=0 build: op=16 -> result 0, Z=1, out_valid at T+1.
